div_unit: RTL and testbench

- Multi-cycle radix-2 restoring divider serving DIV/DIVU in the execute stage.
- Sits directly upstream of the HI/LO register file.
- Produces a 64-bit result {remainder, quotient}. The write-back path splits it into hi (remainder) and lo (quotient).
- Execute stage holds start_i high and stalls the pipeline until ready_o is asserted.

---
 rtl/div_unit.sv | 153 +++++++++++++++
 tb/tb_div_unit.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for DIV/DIVU.
// Result is {remainder, quotient}; operands are converted to magnitudes
// on capture and the signs are re-applied once all iterations finish.
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 signed_div_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic                 start_i,
  input  logic                 annul_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BY_ZERO = 2'd1,
    ST_ON      = 2'd2,
    ST_END     = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LP_CNT_DONE = CNT_W'(WIDTH);

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [WIDTH-1:0]     r_dividend;   // dividend magnitude, MSB shifted out each step
  logic [WIDTH-1:0]     r_divisor;    // divisor magnitude
  logic [WIDTH-1:0]     r_rem;        // partial remainder
  logic [WIDTH-1:0]     r_quot;       // quotient bits shifted in from the LSB
  logic                 r_signed;
  logic                 r_quot_neg;
  logic                 r_rem_neg;
  logic [2*WIDTH-1:0]   r_result;
  logic                 r_ready;

  logic                 w_op1_neg;
  logic                 w_op2_neg;
  logic [WIDTH-1:0]     w_op1_mag;
  logic [WIDTH-1:0]     w_op2_mag;
  logic [WIDTH:0]       w_shift;
  logic [WIDTH:0]       w_diff;
  logic [WIDTH-1:0]     w_quot_fix;
  logic [WIDTH-1:0]     w_rem_fix;

  // Operand magnitudes: only signed mode treats a set MSB as a negative value.
  assign w_op1_neg = signed_div_i & opdata1_i[WIDTH-1];
  assign w_op2_neg = signed_div_i & opdata2_i[WIDTH-1];
  assign w_op1_mag = w_op1_neg ? ({WIDTH{1'b0}} - opdata1_i) : opdata1_i;
  assign w_op2_mag = w_op2_neg ? ({WIDTH{1'b0}} - opdata2_i) : opdata2_i;

  // One restoring step. The partial remainder is always below the divisor,
  // so after the shift a (WIDTH+1)-bit subtract is enough and its MSB is the
  // borrow: set means the trial difference went negative.
  assign w_shift = {r_rem, r_dividend[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_divisor};

  // Final sign correction; quotient follows sign XOR, remainder follows dividend.
  assign w_quot_fix = (r_signed && r_quot_neg) ? ({WIDTH{1'b0}} - r_quot) : r_quot;
  assign w_rem_fix  = (r_signed && r_rem_neg)  ? ({WIDTH{1'b0}} - r_rem)  : r_rem;

  assign result_o = r_result;
  assign ready_o  = r_ready;

  // Divider control FSM together with its datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= {CNT_W{1'b0}};
      r_dividend <= {WIDTH{1'b0}};
      r_divisor  <= {WIDTH{1'b0}};
      r_rem      <= {WIDTH{1'b0}};
      r_quot     <= {WIDTH{1'b0}};
      r_signed   <= 1'b0;
      r_quot_neg <= 1'b0;
      r_rem_neg  <= 1'b0;
      r_result   <= {2*WIDTH{1'b0}};
      r_ready    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_ready  <= 1'b0;
          r_result <= {2*WIDTH{1'b0}};
          if (start_i && !annul_i) begin
            r_dividend <= w_op1_mag;
            r_divisor  <= w_op2_mag;
            r_rem      <= {WIDTH{1'b0}};
            r_quot     <= {WIDTH{1'b0}};
            r_cnt      <= {CNT_W{1'b0}};
            r_signed   <= signed_div_i;
            r_quot_neg <= opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1];
            r_rem_neg  <= opdata1_i[WIDTH-1];
            r_state    <= (opdata2_i == {WIDTH{1'b0}}) ? ST_BY_ZERO : ST_ON;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_BY_ZERO: begin
          if (annul_i) begin
            r_state  <= ST_IDLE;
            r_ready  <= 1'b0;
            r_result <= {2*WIDTH{1'b0}};
          end else begin
            // Undefined architecturally; report zeros so the result is deterministic.
            r_state  <= ST_END;
            r_ready  <= 1'b1;
            r_result <= {2*WIDTH{1'b0}};
          end
        end
        ST_ON: begin
          if (annul_i) begin
            r_state  <= ST_IDLE;
            r_ready  <= 1'b0;
            r_result <= {2*WIDTH{1'b0}};
          end else if (r_cnt == LP_CNT_DONE) begin
            r_state  <= ST_END;
            r_ready  <= 1'b1;
            r_result <= {w_rem_fix, w_quot_fix};
          end else begin
            r_dividend <= {r_dividend[WIDTH-2:0], 1'b0};
            r_cnt      <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            if (!w_diff[WIDTH]) begin
              r_rem  <= w_diff[WIDTH-1:0];
              r_quot <= {r_quot[WIDTH-2:0], 1'b1};
            end else begin
              r_rem  <= w_shift[WIDTH-1:0];
              r_quot <= {r_quot[WIDTH-2:0], 1'b0};
            end
          end
        end
        ST_END: begin
          // Hold the result until the execute stage releases start; never restart from here.
          if (annul_i || !start_i) begin
            r_state  <= ST_IDLE;
            r_ready  <= 1'b0;
            r_result <= {2*WIDTH{1'b0}};
          end else begin
            r_state <= ST_END;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_ready  <= 1'b0;
          r_result <= {2*WIDTH{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: scenario tasks plus randomized operands checked against an
// arithmetic reference model (C-style truncating division).
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        signed_div;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;

  int checks;
  int failures;

  div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {remainder, quotient}; zero divisor gives all zeros.
  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Runs one operation with start held; optional operand change, annul or
  // reset before a given edge number (E0 = start-sampling edge).
  task automatic do_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                       input int chg_at, input logic [31:0] chg_val,
                       input int annul_at, input int rst_at,
                       output int lat, output logic [63:0] res,
                       output logic post_ready, output logic [63:0] post_res,
                       output logic drop_ready, output logic [63:0] drop_res);
    lat = -1;
    res = 64'd0;
    post_ready = 1'b0;
    post_res = 64'd0;
    signed_div = s;
    op1 = a;
    op2 = b;
    start = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 40; k++) begin
      if (k == chg_at) op1 = chg_val;
      if (k + 1 == annul_at) begin annul = 1'b1; start = 1'b0; end
      if (k + 1 == rst_at) begin rst = 1'b1; start = 1'b0; end
      @(posedge clk); #1;
      if (k + 1 == annul_at) begin annul = 1'b0; post_ready = ready; post_res = result; end
      if (k + 1 == rst_at) begin rst = 1'b0; post_ready = ready; post_res = result; end
      if (ready && lat < 0) begin
        lat = k + 1;
        res = result;
        break;
      end
    end
    start = 1'b0;
    @(posedge clk); #1;
    drop_ready = ready;
    drop_res = result;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; annul = 1'b0; signed_div = 1'b0;
    op1 = 32'd50; op2 = 32'd3;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0;
    checks++;
    if (ready !== 1'b0 || result !== 64'd0) begin
      failures++;
      $display("FAIL reset: ready=%b result=%h required ready=0 result=0", ready, result);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ready !== 1'b0 || result !== 64'd0) begin
      failures++;
      $display("FAIL reset_idle: ready=%b result=%h required 0/0", ready, result);
    end
  endtask

  task automatic test_directed();
    logic [31:0] va [6] = '{32'd100, 32'hFFFFFFF9, 32'd7, 32'hFFFFFFF9, 32'd5, 32'h80000000};
    logic [31:0] vb [6] = '{32'd7, 32'd2, 32'hFFFFFFFE, 32'd2, 32'd0, 32'hFFFFFFFF};
    logic        vs [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [63:0] ve [6] = '{64'h00000002_0000000E, 64'hFFFFFFFF_FFFFFFFD, 64'h00000001_FFFFFFFD,
                            64'h00000001_7FFFFFFC, 64'h0, 64'h00000000_80000000};
    int          vl [6] = '{33, 33, 33, 33, 1, 33};
    int lat; logic [63:0] res, pres, dres; logic prdy, drdy;
    for (int i = 0; i < 6; i++) begin
      do_op(vs[i], va[i], vb[i], -1, 32'd0, -1, -1, lat, res, prdy, pres, drdy, dres);
      checks++;
      if (lat !== vl[i]) begin
        failures++;
        $display("FAIL directed_latency[%0d]: got %0d required %0d", i, lat, vl[i]);
      end
      checks++;
      if (res !== ve[i]) begin
        failures++;
        $display("FAIL directed_result[%0d]: got %h required %h", i, res, ve[i]);
      end
      checks++;
      if (drdy !== 1'b0 || dres !== 64'd0) begin
        failures++;
        $display("FAIL directed_drop[%0d]: ready=%b result=%h required 0/0", i, drdy, dres);
      end
    end
  endtask

  task automatic test_operand_change_annul();
    int lat; logic [63:0] res, pres, dres; logic prdy, drdy;
    do_op(1'b0, 32'd1000, 32'd10, 5, 32'd77777, -1, -1, lat, res, prdy, pres, drdy, dres);
    checks++;
    if (lat !== 33 || res !== 64'h00000000_00000064) begin
      failures++;
      $display("FAIL operand_change: lat=%0d result=%h required 33 / 0000000000000064", lat, res);
    end
    do_op(1'b0, 32'd1000, 32'd10, -1, 32'd0, 10, -1, lat, res, prdy, pres, drdy, dres);
    checks++;
    if (lat !== -1 || prdy !== 1'b0 || pres !== 64'd0) begin
      failures++;
      $display("FAIL annul_on: lat=%0d ready=%b result=%h required no ready, 0", lat, prdy, pres);
    end
    do_op(1'b0, 32'd9, 32'd3, -1, 32'd0, -1, -1, lat, res, prdy, pres, drdy, dres);
    checks++;
    if (lat !== 33 || res !== 64'h00000000_00000003) begin
      failures++;
      $display("FAIL after_annul: lat=%0d result=%h required 33 / 0000000000000003", lat, res);
    end
    // annul while parked in the by-zero state
    do_op(1'b0, 32'd5, 32'd0, -1, 32'd0, 1, -1, lat, res, prdy, pres, drdy, dres);
    checks++;
    if (lat !== -1 || prdy !== 1'b0) begin
      failures++;
      $display("FAIL annul_by_zero: lat=%0d ready=%b required no ready", lat, prdy);
    end
  endtask

  task automatic test_reset_mid_op();
    int lat; logic [63:0] res, pres, dres; logic prdy, drdy;
    do_op(1'b1, 32'hFFFF0000, 32'd17, -1, 32'd0, -1, 20, lat, res, prdy, pres, drdy, dres);
    checks++;
    if (lat !== -1 || prdy !== 1'b0 || pres !== 64'd0) begin
      failures++;
      $display("FAIL reset_mid_op: lat=%0d ready=%b result=%h required no ready, 0", lat, prdy, pres);
    end
    do_op(1'b1, 32'hFFFF0000, 32'd17, -1, 32'd0, -1, -1, lat, res, prdy, pres, drdy, dres);
    checks++;
    if (lat !== 33 || res !== ref_div(1'b1, 32'hFFFF0000, 32'd17)) begin
      failures++;
      $display("FAIL after_reset: lat=%0d result=%h required 33 / %h", lat, res,
               ref_div(1'b1, 32'hFFFF0000, 32'd17));
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp_a;
    int lat;
    exp_a = ref_div(1'b0, 32'd123456, 32'd789);
    signed_div = 1'b0; op1 = 32'd123456; op2 = 32'd789; start = 1'b1;
    @(posedge clk); #1;
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (ready) begin lat = k + 1; break; end
    end
    checks++;
    if (lat !== 33) begin
      failures++;
      $display("FAIL b2b_latency: got %0d required 33", lat);
    end
    // start held through the done state: output must hold and never restart
    for (int k = 0; k < 45; k++) begin
      @(posedge clk); #1;
      checks++;
      if (ready !== 1'b1 || result !== exp_a) begin
        failures++;
        $display("FAIL b2b_hold[%0d]: ready=%b result=%h required 1 / %h", k, ready, result, exp_a);
        break;
      end
    end
    // annul in the done state with start still high
    annul = 1'b1;
    @(posedge clk); #1;
    annul = 1'b0; start = 1'b0;
    checks++;
    if (ready !== 1'b0 || result !== 64'd0) begin
      failures++;
      $display("FAIL annul_end: ready=%b result=%h required 0/0", ready, result);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int lat, exp_lat; logic [63:0] res, pres, dres, exp_r; logic prdy, drdy;
    logic s; logic [31:0] a, b; int sel;
    for (int i = 0; i < 1000; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      if ($urandom_range(0, 15) == 0) a = 32'h80000000;
      sel = $urandom_range(0, 15);
      case (sel)
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = 32'hFFFFFFFF;
        3: b = 32'hFFFFFFFF - 32'($urandom_range(0, 15));
        default: b = $urandom;
      endcase
      exp_r = ref_div(s, a, b);
      exp_lat = (b == 32'd0) ? 1 : 33;
      do_op(s, a, b, -1, 32'd0, -1, -1, lat, res, prdy, pres, drdy, dres);
      checks++;
      if (lat !== exp_lat) begin
        failures++;
        $display("FAIL rand_latency[%0d]: s=%b %h/%h got %0d required %0d", i, s, a, b, lat, exp_lat);
      end
      checks++;
      if (res !== exp_r) begin
        failures++;
        $display("FAIL rand_result[%0d]: s=%b %h/%h got %h required %h", i, s, a, b, res, exp_r);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0;
    op1 = 32'd0; op2 = 32'd0;
    test_reset();
    test_directed();
    test_operand_change_annul();
    test_reset_mid_op();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
